// File: rtl/stream_seq_checker_if.sv
// Word stream carrying an incrementing sequence into the checker.
//
// Handshake: a word moves on every rising clk edge where valid and ready
// are both high. The source holds valid and data stable until that edge.
// ready never depends on valid.
interface stream_seq_checker_if #(
    parameter int W = 16
);
    logic         valid;
    logic [W-1:0] data;
    logic         ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_seq_checker.sv
// stream_seq_checker: consumes a valid/ready word stream and checks that each
// accepted word equals the previous one plus STEP (modulo 2^W). It locks onto
// the first word after enable. It reports a sticky error flag, a saturating
// error count, an accepted-word count and the first mismatching pair.
//
// Optional build macro STREAM_SEQ_CHECKER_THROTTLE_EN adds a 16-bit LFSR that
// drops in_ready on roughly one cycle in four. This exercises upstream
// backpressure handling. Without the macro, ready is high whenever the checker
// is not idle.
module stream_seq_checker #(
    parameter int           W         = 16,
    parameter logic [W-1:0] STEP      = W'(1),
    parameter int           ERR_CNT_W = 8,
    parameter bit           RESYNC    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 en,
    input  logic                 clr,
    stream_seq_checker_if.slave  stream,
    output logic                 locked,
    output logic [31:0]          word_cnt,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [W-1:0]         err_expected,
    output logic [W-1:0]         err_got,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t       state;
    logic [W-1:0] expected;
    logic         ready;
    logic         accept;
    logic         match;
    logic [W-1:0] mismatch_next;

`ifdef STREAM_SEQ_CHECKER_THROTTLE_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Fibonacci LFSR, taps 16/14/13/11; frozen while idle so each lock
    // attempt sees the sequence continue from where it stopped.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            lfsr <= 16'hACE1;
        end else if (state != IDLE) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign ready = (state != IDLE) && (lfsr[1:0] != 2'b00);
`else
    assign ready = (state != IDLE);
`endif

    assign stream.ready  = ready;
    assign accept        = stream.valid & ready;
    assign match         = (stream.data == expected);
    // After a miss, either trust the received word (resync) or keep counting
    // from where the sequence should have been.
    assign mismatch_next = RESYNC ? (stream.data + STEP) : (expected + STEP);
    assign dbg_state     = state;

    // Sequencing FSM: lock on the first accepted word, then track the expected
    // value. Dropping en always returns to IDLE. A word accepted in that same
    // cycle still advances expected.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            locked   <= 1'b0;
            expected <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= SYNC;
                    end
                end
                SYNC: begin
                    if (accept) begin
                        expected <= stream.data + STEP;
                        locked   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        expected <= match ? (expected + STEP) : mismatch_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (!en) begin
                state  <= IDLE;
                locked <= 1'b0;
            end
        end
    end

    // Status counters and first-mismatch capture. clr takes priority over an
    // accept in the same cycle. These registers survive en going low.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            word_cnt     <= '0;
            err          <= 1'b0;
            err_cnt      <= '0;
            err_expected <= '0;
            err_got      <= '0;
        end else if (clr) begin
            word_cnt     <= '0;
            err          <= 1'b0;
            err_cnt      <= '0;
            err_expected <= '0;
            err_got      <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + 32'd1;
            if ((state == RUN) && !match) begin
                err <= 1'b1;
                if (err_cnt != {ERR_CNT_W{1'b1}}) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (!err) begin
                    err_expected <= expected;
                    err_got      <= stream.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_seq_checker.sv
// Bench for stream_seq_checker. Two instances share one stimulus stream:
// index 0 has RESYNC=1 and index 1 has RESYNC=0. A per-instance reference
// model is updated on every handshake the bench observes.
module tb_stream_seq_checker;
    localparam int W = 16;
    localparam logic [1:0] ST_IDLE = 2'd0;

    logic clk = 1'b0;
    logic rst_;
    logic en;
    logic clr;

    stream_seq_checker_if #(.W(W)) if_a ();
    stream_seq_checker_if #(.W(W)) if_b ();

    logic        o_locked[2];
    logic [31:0] o_words[2];
    logic        o_err[2];
    logic [7:0]  o_errcnt[2];
    logic [15:0] o_eexp[2];
    logic [15:0] o_egot[2];
    logic [1:0]  o_state[2];
    logic        o_ready[2];

    assign o_ready[0] = if_a.ready;
    assign o_ready[1] = if_b.ready;

    stream_seq_checker #(.W(W), .STEP(16'd1), .ERR_CNT_W(8), .RESYNC(1'b1)) dut_a (
        .clk(clk), .rst_(rst_), .en(en), .clr(clr), .stream(if_a),
        .locked(o_locked[0]), .word_cnt(o_words[0]), .err(o_err[0]),
        .err_cnt(o_errcnt[0]), .err_expected(o_eexp[0]), .err_got(o_egot[0]),
        .dbg_state(o_state[0])
    );

    stream_seq_checker #(.W(W), .STEP(16'd1), .ERR_CNT_W(8), .RESYNC(1'b0)) dut_b (
        .clk(clk), .rst_(rst_), .en(en), .clr(clr), .stream(if_b),
        .locked(o_locked[1]), .word_cnt(o_words[1]), .err(o_err[1]),
        .err_cnt(o_errcnt[1]), .err_expected(o_eexp[1]), .err_got(o_egot[1]),
        .dbg_state(o_state[1])
    );

    // Clock generation.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int stall_cycles = 0;

    // Reference model: what each instance should report, from the rules alone.
    bit          m_locked[2];
    logic [15:0] m_next[2];
    logic [31:0] m_words[2];
    int          m_errs[2];
    bit          m_err[2];
    logic [15:0] m_cap_exp[2];
    logic [15:0] m_cap_got[2];

    function automatic int sat8(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_locked[k] = 0; m_next[k] = 16'd0; m_words[k] = 32'd0; m_errs[k] = 0;
            m_err[k] = 0; m_cap_exp[k] = 16'd0; m_cap_got[k] = 16'd0;
        end
    endfunction

    function automatic void model_clear(input int k);
        m_words[k] = 32'd0; m_errs[k] = 0; m_err[k] = 0;
        m_cap_exp[k] = 16'd0; m_cap_got[k] = 16'd0;
    endfunction

    function automatic void model_accept(input int k, input logic [15:0] d);
        if (!m_locked[k]) begin
            m_locked[k] = 1;
            m_next[k] = d + 16'd1;
        end else if (d !== m_next[k]) begin
            if (!m_err[k]) begin
                m_cap_exp[k] = m_next[k];
                m_cap_got[k] = d;
            end
            m_err[k] = 1;
            m_errs[k]++;
            m_next[k] = (k == 0) ? d + 16'd1 : m_next[k] + 16'd1;
        end else begin
            m_next[k] = m_next[k] + 16'd1;
        end
        m_words[k] = m_words[k] + 32'd1;
    endfunction

    // One clock cycle of stimulus. Inputs are applied at the falling edge and
    // handshakes are evaluated against the current ready values.
    task automatic step(input bit v, input logic [15:0] d, input bit c, output bit acc);
        if_a.valid = v; if_a.data = d;
        if_b.valid = v; if_b.data = d;
        clr = c;
        acc = v && if_a.ready;
        if (v && !if_a.ready) stall_cycles++;
        if (v && if_a.ready) model_accept(0, d);
        if (v && if_b.ready) model_accept(1, d);
        if (c) begin model_clear(0); model_clear(1); end
        if (!en) begin m_locked[0] = 0; m_locked[1] = 0; end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d);
        bit acc;
        int budget;
        budget = 0;
        do begin
            step(1'b1, d, 1'b0, acc);
            budget++;
        end while (!acc && budget < 200);
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout word=%h not accepted within %0d cycles", d, budget);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, acc);
    endtask

    // Disable, clear, re-enable: the checker ends up in SYNC with zeroed status.
    task automatic relock();
        bit acc;
        en = 1'b0;
        step(1'b0, 16'h0, 1'b1, acc);
        en = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_ready[k] !== 1'b0) begin failures++; $display("FAIL reset_ready[%0d] got=%b exp=0", k, o_ready[k]); end
            checks++; if (o_locked[k] !== 1'b0) begin failures++; $display("FAIL reset_locked[%0d] got=%b exp=0", k, o_locked[k]); end
            checks++; if (o_words[k] !== 32'd0) begin failures++; $display("FAIL reset_word_cnt[%0d] got=%0d exp=0", k, o_words[k]); end
            checks++; if (o_err[k] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d] got=%b exp=0", k, o_err[k]); end
            checks++; if (o_errcnt[k] !== 8'd0) begin failures++; $display("FAIL reset_err_cnt[%0d] got=%0d exp=0", k, o_errcnt[k]); end
            checks++; if (o_eexp[k] !== 16'd0 || o_egot[k] !== 16'd0) begin failures++; $display("FAIL reset_capture[%0d] got=%h/%h exp=0/0", k, o_eexp[k], o_egot[k]); end
            checks++; if (o_state[k] !== ST_IDLE) begin failures++; $display("FAIL reset_state[%0d] got=%0d exp=%0d", k, o_state[k], ST_IDLE); end
        end
    endtask

    task automatic test_stream();
        en = 1'b1;
        idle(1);
        checks++; if (o_locked[0] !== 1'b0) begin failures++; $display("FAIL stream_prelock got=%b exp=0", o_locked[0]); end
        for (int i = 0; i < 256; i++) begin
            send_word(16'(i));
            if (i == 0) begin
                for (int k = 0; k < 2; k++) begin
                    checks++; if (o_locked[k] !== 1'b1) begin failures++; $display("FAIL stream_locked[%0d] got=%b exp=1", k, o_locked[k]); end
                end
            end
        end
        idle(1);
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_words[k] !== 32'd256) begin failures++; $display("FAIL stream_word_cnt[%0d] got=%0d exp=256", k, o_words[k]); end
            checks++; if (o_err[k] !== 1'b0 || o_errcnt[k] !== 8'd0) begin failures++; $display("FAIL stream_err[%0d] got=%b/%0d exp=0/0", k, o_err[k], o_errcnt[k]); end
        end
    endtask

    task automatic test_wrap();
        relock();
        send_word(16'hFFFE); send_word(16'hFFFF); send_word(16'h0000); send_word(16'h0001);
        idle(1);
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_err[k] !== 1'b0 || o_errcnt[k] !== 8'd0) begin failures++; $display("FAIL wrap_err[%0d] got=%b/%0d exp=0/0", k, o_err[k], o_errcnt[k]); end
            checks++; if (o_words[k] !== 32'd4) begin failures++; $display("FAIL wrap_word_cnt[%0d] got=%0d exp=4", k, o_words[k]); end
        end
    endtask

    task automatic test_resync();
        relock();
        send_word(16'd5); send_word(16'd6); send_word(16'd9); send_word(16'd10);
        idle(1);
        checks++; if (o_err[0] !== 1'b1 || o_errcnt[0] !== 8'd1) begin failures++; $display("FAIL resync1_err got=%b/%0d exp=1/1", o_err[0], o_errcnt[0]); end
        checks++; if (o_eexp[0] !== 16'd7 || o_egot[0] !== 16'd9) begin failures++; $display("FAIL resync1_capture got=%0d/%0d exp=7/9", o_eexp[0], o_egot[0]); end
        checks++; if (o_err[1] !== 1'b1 || o_errcnt[1] !== 8'd2) begin failures++; $display("FAIL resync0_err got=%b/%0d exp=1/2", o_err[1], o_errcnt[1]); end
        checks++; if (o_eexp[1] !== 16'd7 || o_egot[1] !== 16'd9) begin failures++; $display("FAIL resync0_capture got=%0d/%0d exp=7/9", o_eexp[1], o_egot[1]); end
    endtask

    task automatic test_saturate();
        logic [15:0] d;
        relock();
        d = 16'h1000;
        send_word(d);
        for (int i = 0; i < 300; i++) begin
            d = m_next[0] + 16'd2 + 16'($urandom_range(0, 50));
            send_word(d);
        end
        idle(1);
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_errcnt[k] !== 8'hFF) begin failures++; $display("FAIL sat_err_cnt[%0d] got=%h exp=ff", k, o_errcnt[k]); end
            checks++; if (o_eexp[k] !== m_cap_exp[k] || o_egot[k] !== m_cap_got[k]) begin failures++; $display("FAIL sat_capture[%0d] got=%h/%h exp=%h/%h", k, o_eexp[k], o_egot[k], m_cap_exp[k], m_cap_got[k]); end
            checks++; if (o_eexp[k] !== 16'h1001) begin failures++; $display("FAIL sat_first_expected[%0d] got=%h exp=1001", k, o_eexp[k]); end
        end
    endtask

    task automatic test_random();
        bit acc;
        bit v;
        bit c;
        logic [15:0] d;
        relock();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            d = ($urandom_range(0, 9) == 0) ? 16'($urandom) : m_next[0];
            step(v, d, c, acc);
        end
        idle(1);
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_words[k] !== m_words[k]) begin failures++; $display("FAIL rand_word_cnt[%0d] got=%0d exp=%0d", k, o_words[k], m_words[k]); end
            checks++; if (o_err[k] !== m_err[k]) begin failures++; $display("FAIL rand_err[%0d] got=%b exp=%b", k, o_err[k], m_err[k]); end
            checks++; if (o_errcnt[k] !== 8'(sat8(m_errs[k]))) begin failures++; $display("FAIL rand_err_cnt[%0d] got=%0d exp=%0d", k, o_errcnt[k], sat8(m_errs[k])); end
            checks++; if (o_eexp[k] !== m_cap_exp[k] || o_egot[k] !== m_cap_got[k]) begin failures++; $display("FAIL rand_capture[%0d] got=%h/%h exp=%h/%h", k, o_eexp[k], o_egot[k], m_cap_exp[k], m_cap_got[k]); end
            checks++; if (o_locked[k] !== m_locked[k]) begin failures++; $display("FAIL rand_locked[%0d] got=%b exp=%b", k, o_locked[k], m_locked[k]); end
        end
    endtask

    task automatic test_throttle();
        relock();
        stall_cycles = 0;
        for (int i = 0; i < 1000; i++) send_word(16'(i));
        idle(1);
`ifdef STREAM_SEQ_CHECKER_THROTTLE_EN
        checks++; if (stall_cycles == 0) begin failures++; $display("FAIL throttle_stalls got=%0d exp=>0", stall_cycles); end
`else
        checks++; if (stall_cycles != 0) begin failures++; $display("FAIL throttle_stalls got=%0d exp=0", stall_cycles); end
`endif
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_words[k] !== 32'd1000) begin failures++; $display("FAIL throttle_word_cnt[%0d] got=%0d exp=1000", k, o_words[k]); end
            checks++; if (o_err[k] !== 1'b0) begin failures++; $display("FAIL throttle_err[%0d] got=%b exp=0", k, o_err[k]); end
        end
    endtask

    task automatic test_en_drop();
        bit acc;
        relock();
        for (int i = 0; i < 6; i++) send_word(16'(100 + i));
        send_word(16'd200);
        send_word(16'd201);
        en = 1'b0;
        step(1'b1, m_next[0], 1'b0, acc);
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_ready[k] !== 1'b0 || o_locked[k] !== 1'b0) begin failures++; $display("FAIL endrop_ready_locked[%0d] got=%b/%b exp=0/0", k, o_ready[k], o_locked[k]); end
            checks++; if (o_state[k] !== ST_IDLE) begin failures++; $display("FAIL endrop_state[%0d] got=%0d exp=%0d", k, o_state[k], ST_IDLE); end
            checks++; if (o_words[k] !== m_words[k] || o_errcnt[k] !== 8'(sat8(m_errs[k]))) begin failures++; $display("FAIL endrop_counts[%0d] got=%0d/%0d exp=%0d/%0d", k, o_words[k], o_errcnt[k], m_words[k], sat8(m_errs[k])); end
            checks++; if (o_err[k] !== 1'b1) begin failures++; $display("FAIL endrop_err[%0d] got=%b exp=1", k, o_err[k]); end
        end
        step(1'b0, 16'h0, 1'b1, acc);
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_words[k] !== 32'd0 || o_err[k] !== 1'b0 || o_errcnt[k] !== 8'd0) begin failures++; $display("FAIL clr_counts[%0d] got=%0d/%b/%0d exp=0/0/0", k, o_words[k], o_err[k], o_errcnt[k]); end
            checks++; if (o_eexp[k] !== 16'd0 || o_egot[k] !== 16'd0) begin failures++; $display("FAIL clr_capture[%0d] got=%h/%h exp=0/0", k, o_eexp[k], o_egot[k]); end
        end
    endtask

    task automatic test_async_reset();
        bit acc;
        en = 1'b1;
        idle(1);
        send_word(16'd50); send_word(16'd51); send_word(16'd60);
        for (int i = 0; i < 20 && !if_a.ready; i++) step(1'b0, 16'h0, 1'b0, acc);
        if_a.valid = 1'b1; if_a.data = 16'd61;
        if_b.valid = 1'b1; if_b.data = 16'd61;
        rst_ = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_ready[k] !== 1'b0 || o_locked[k] !== 1'b0 || o_state[k] !== ST_IDLE) begin failures++; $display("FAIL arst_ctrl[%0d] got=%b/%b/%0d exp=0/0/0", k, o_ready[k], o_locked[k], o_state[k]); end
            checks++; if (o_words[k] !== 32'd0 || o_err[k] !== 1'b0 || o_errcnt[k] !== 8'd0) begin failures++; $display("FAIL arst_counts[%0d] got=%0d/%b/%0d exp=0/0/0", k, o_words[k], o_err[k], o_errcnt[k]); end
            checks++; if (o_eexp[k] !== 16'd0 || o_egot[k] !== 16'd0) begin failures++; $display("FAIL arst_capture[%0d] got=%h/%h exp=0/0", k, o_eexp[k], o_egot[k]); end
        end
        if_a.valid = 1'b0; if_b.valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_ = 1'b1;
        idle(1);
        send_word(16'd7); send_word(16'd8);
        idle(1);
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_words[k] !== 32'd2 || o_err[k] !== 1'b0 || o_locked[k] !== 1'b1) begin failures++; $display("FAIL arst_restart[%0d] got=%0d/%b/%b exp=2/0/1", k, o_words[k], o_err[k], o_locked[k]); end
        end
    endtask

    // Test sequence.
    initial begin
        rst_ = 1'b1; en = 1'b0; clr = 1'b0;
        if_a.valid = 1'b0; if_a.data = '0;
        if_b.valid = 1'b0; if_b.data = '0;
        model_reset();
        #1 rst_ = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst_ = 1'b1;
        idle(2);
        test_reset();
        test_stream();
        test_wrap();
        test_resync();
        test_saturate();
        test_random();
        test_throttle();
        test_en_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so a stuck handshake still ends in a summary.
    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout bench did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
